// File: rtl/fb_port_arbiter_if.sv
// Bundle of the frame-buffer arbiter's scan-out, writer, clear and RAM-side signals.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface fb_port_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 4
);
  logic [ADDR_W-1:0] VGA_ADDR;
  logic [DATA_W-1:0] VGA_DATA;

  logic              A_REQ;
  logic [ADDR_W-1:0] A_ADDR;
  logic [DATA_W-1:0] A_DATA;
  logic              A_ACK;

  logic              B_REQ;
  logic [ADDR_W-1:0] B_ADDR;
  logic [DATA_W-1:0] B_DATA;
  logic              B_ACK;

  logic              CLR_START;
  logic [DATA_W-1:0] CLR_COLOR;
  logic              CLR_BUSY;

  logic [ADDR_W-1:0] RAM_ADDR;
  logic [DATA_W-1:0] RAM_WDATA;
  logic              RAM_WE;
  logic [DATA_W-1:0] RAM_RDATA;

  modport slave (
    input  VGA_ADDR,
    output VGA_DATA,
    input  A_REQ, A_ADDR, A_DATA,
    output A_ACK,
    input  B_REQ, B_ADDR, B_DATA,
    output B_ACK,
    input  CLR_START, CLR_COLOR,
    output CLR_BUSY,
    output RAM_ADDR, RAM_WDATA, RAM_WE,
    input  RAM_RDATA
  );

  modport master (
    output VGA_ADDR,
    input  VGA_DATA,
    output A_REQ, A_ADDR, A_DATA,
    input  A_ACK,
    output B_REQ, B_ADDR, B_DATA,
    input  B_ACK,
    output CLR_START, CLR_COLOR,
    input  CLR_BUSY,
    input  RAM_ADDR, RAM_WDATA, RAM_WE,
    output RAM_RDATA
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: VGA scan-out reads first, then the clear
// engine, then writers A/B round-robin; at most one RAM access per cycle.
module fb_port_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 4,
  parameter int FB_WORDS = 19200
) (
  input logic                VGA_CLK,
  input logic                RESET,
  fb_port_arbiter_if.slave   bus
);

  typedef enum logic {
    CLR_IDLE,
    CLR_RUN
  } clr_state_t;

  localparam logic [ADDR_W-1:0] FB_LIMIT = ADDR_W'(FB_WORDS);
  localparam logic [ADDR_W-1:0] FB_LAST  = ADDR_W'(FB_WORDS - 1);

  clr_state_t        state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic [DATA_W-1:0] clr_color;
  logic              clr_load;

  logic [ADDR_W-1:0] prev_addr;
  logic              force_rd;
  logic [1:0]        rd_vld;
  logic [1:0]        rd_oob;
  logic [DATA_W-1:0] vga_data_q;

  // rr_b: 0 = pointer at A (B wins a tie), 1 = pointer at B
  logic              rr_b, rr_b_nxt;

  logic [ADDR_W-1:0] ram_addr_q, ram_addr_nxt;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_nxt;
  logic              ram_we_q, ram_we_nxt;

  logic              rd_req;
  logic              vga_in_range;
  logic              rd_issue;
  logic              rd_skip;
  logic              a_ack, b_ack;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign rd_req       = (bus.VGA_ADDR != prev_addr) || force_rd;
  assign vga_in_range = bus.VGA_ADDR < FB_LIMIT;
  assign rd_issue     = rd_req && vga_in_range;
  assign rd_skip      = rd_req && !vga_in_range;

  always_comb begin
    state_nxt     = state;
    clr_cnt_nxt   = clr_cnt;
    clr_load      = 1'b0;
    rr_b_nxt      = rr_b;
    a_ack         = 1'b0;
    b_ack         = 1'b0;
    wr_addr       = bus.A_ADDR;
    wr_data       = bus.A_DATA;
    ram_addr_nxt  = ram_addr_q;
    ram_wdata_nxt = ram_wdata_q;
    ram_we_nxt    = 1'b0;

    if (state == CLR_IDLE && bus.CLR_START) begin
      state_nxt   = CLR_RUN;
      clr_cnt_nxt = '0;
      clr_load    = 1'b1;
    end

    if (rd_issue) begin
      ram_addr_nxt = bus.VGA_ADDR;
    end else begin
      case (state)
        CLR_RUN: begin
          ram_addr_nxt  = clr_cnt;
          ram_wdata_nxt = clr_color;
          ram_we_nxt    = 1'b1;
          clr_cnt_nxt   = clr_cnt + ADDR_W'(1);
          if (clr_cnt == FB_LAST) begin
            state_nxt = CLR_IDLE;
          end
        end
        default: begin
          if (bus.A_REQ && bus.B_REQ) begin
            a_ack    = rr_b;
            b_ack    = !rr_b;
            rr_b_nxt = !rr_b;
          end else begin
            a_ack = bus.A_REQ;
            b_ack = bus.B_REQ;
          end
          if (b_ack) begin
            wr_addr = bus.B_ADDR;
            wr_data = bus.B_DATA;
          end
          // An out-of-range write is still acked so the requester can move on.
          if ((a_ack || b_ack) && wr_addr < FB_LIMIT) begin
            ram_addr_nxt  = wr_addr;
            ram_wdata_nxt = wr_data;
            ram_we_nxt    = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      state <= CLR_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      clr_cnt     <= '0;
      clr_color   <= '0;
      rr_b        <= 1'b0;
      prev_addr   <= '0;
      force_rd    <= 1'b1;
      rd_vld      <= '0;
      rd_oob      <= '0;
      vga_data_q  <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
    end else begin
      clr_cnt     <= clr_cnt_nxt;
      if (clr_load) begin
        clr_color <= bus.CLR_COLOR;
      end
      rr_b        <= rr_b_nxt;
      prev_addr   <= bus.VGA_ADDR;
      force_rd    <= 1'b0;
      // Skipped reads ride the same pipeline so VGA_DATA=0 lands with read latency.
      rd_vld      <= {rd_vld[0], rd_req};
      rd_oob      <= {rd_oob[0], rd_skip};
      if (rd_vld[1]) begin
        vga_data_q <= rd_oob[1] ? '0 : bus.RAM_RDATA;
      end
      ram_addr_q  <= ram_addr_nxt;
      ram_wdata_q <= ram_wdata_nxt;
      ram_we_q    <= ram_we_nxt;
    end
  end

  assign bus.VGA_DATA  = vga_data_q;
  assign bus.A_ACK     = a_ack;
  assign bus.B_ACK     = b_ack;
  assign bus.CLR_BUSY  = (state == CLR_RUN);
  assign bus.RAM_ADDR  = ram_addr_q;
  assign bus.RAM_WDATA = ram_wdata_q;
  assign bus.RAM_WE    = ram_we_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a registered-read RAM model.
module tb_fb_port_arbiter;
  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 4;
  localparam int FB_WORDS = 19200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fb_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_WORDS(FB_WORDS)) dut (
    .VGA_CLK (clk),
    .RESET   (rst),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic preload = 1'b1;
  logic [DATA_W-1:0] mem [0:FB_WORDS-1];

  always @(posedge clk) begin
    if (preload) begin
      for (int unsigned i = 0; i < FB_WORDS; i++) mem[i] <= '0;
      mem[4] <= 4'h6;
      mem[5] <= 4'hA;
      mem[6] <= 4'h9;
    end else if (bus.RAM_WE && bus.RAM_ADDR < ADDR_W'(FB_WORDS)) begin
      mem[bus.RAM_ADDR] <= bus.RAM_WDATA;
    end
    bus.RAM_RDATA <= (bus.RAM_ADDR < ADDR_W'(FB_WORDS)) ? mem[bus.RAM_ADDR] : '0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wr;
    int bad;
    int exp_a;
    int cyc;
    logic done;
    logic found;
    logic last_we;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] va;

    bus.VGA_ADDR  = 19'd4;
    bus.A_REQ     = 1'b0;
    bus.A_ADDR    = '0;
    bus.A_DATA    = '0;
    bus.B_REQ     = 1'b0;
    bus.B_ADDR    = '0;
    bus.B_DATA    = '0;
    bus.CLR_START = 1'b0;
    bus.CLR_COLOR = '0;

    step();
    step();
    chk("rst_vga_data", bus.VGA_DATA, 0);
    chk("rst_ram_we", bus.RAM_WE, 0);
    chk("rst_ram_addr", bus.RAM_ADDR, 0);
    chk("rst_ram_wdata", bus.RAM_WDATA, 0);
    chk("rst_clr_busy", bus.CLR_BUSY, 0);
    preload = 1'b0;
    rst = 1'b0;

    // First post-reset cycle reads VGA_ADDR=4
    step();
    chk("init_rd_addr", bus.RAM_ADDR, 4);
    chk("init_rd_we", bus.RAM_WE, 0);
    step();
    chk("init_vga_lat", bus.VGA_DATA, 0);
    step();
    chk("init_vga_data", bus.VGA_DATA, 6);

    // Address change 4 -> 5
    bus.VGA_ADDR = 19'd5;
    step();
    chk("rd5_addr", bus.RAM_ADDR, 5);
    chk("rd5_we", bus.RAM_WE, 0);
    step();
    chk("rd5_vga_hold", bus.VGA_DATA, 6);
    step();
    chk("rd5_vga_data", bus.VGA_DATA, 4'hA);

    // Round robin: B, A, B, A
    bus.A_REQ = 1'b1; bus.A_ADDR = 19'd100; bus.A_DATA = 4'h1;
    bus.B_REQ = 1'b1; bus.B_ADDR = 19'd200; bus.B_DATA = 4'h2;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_a_ack", bus.A_ACK, (k % 2 == 1) ? 1 : 0);
      chk("rr_b_ack", bus.B_ACK, (k % 2 == 0) ? 1 : 0);
      step();
      chk("rr_we", bus.RAM_WE, 1);
      chk("rr_addr", bus.RAM_ADDR, (k % 2 == 0) ? 200 : 100);
      chk("rr_wdata", bus.RAM_WDATA, (k % 2 == 0) ? 2 : 1);
    end
    bus.A_REQ = 1'b0;
    bus.B_REQ = 1'b0;

    // Read pre-empts writer A
    bus.A_REQ = 1'b1; bus.A_ADDR = 19'd300; bus.A_DATA = 4'h7;
    bus.VGA_ADDR = 19'd6;
    #1;
    chk("blk_a_ack0", bus.A_ACK, 0);
    step();
    chk("blk_rd_addr", bus.RAM_ADDR, 6);
    chk("blk_rd_we", bus.RAM_WE, 0);
    chk("blk_a_ack1", bus.A_ACK, 1);
    step();
    chk("blk_wr_we", bus.RAM_WE, 1);
    chk("blk_wr_addr", bus.RAM_ADDR, 300);
    chk("blk_wr_data", bus.RAM_WDATA, 7);
    bus.A_REQ = 1'b0;
    step();
    chk("blk_vga_data", bus.VGA_DATA, 9);

    // Out-of-range read and write
    bus.VGA_ADDR = 19'h7FFF0;
    bus.A_REQ = 1'b1; bus.A_ADDR = 19'd19200; bus.A_DATA = 4'h5;
    #1;
    chk("oob_a_ack", bus.A_ACK, 1);
    step();
    chk("oob_we", bus.RAM_WE, 0);
    chk("oob_addr_hold", bus.RAM_ADDR, 300);
    bus.A_REQ = 1'b0;
    step();
    chk("oob_vga_hold", bus.VGA_DATA, 9);
    step();
    chk("oob_vga_zero", bus.VGA_DATA, 0);

    // Full clear with VGA address changing every 4 cycles
    va = 19'd10;
    bus.VGA_ADDR  = va;
    bus.CLR_START = 1'b1;
    bus.CLR_COLOR = 4'h3;
    step();
    bus.CLR_START = 1'b0;
    chk("clr_busy_rise", bus.CLR_BUSY, 1);
    bus.A_REQ = 1'b1; bus.A_ADDR = 19'd500; bus.A_DATA = 4'hF;
    wr = 0; bad = 0; exp_a = 0; cyc = 0; done = 1'b0;
    last_we = 1'b0; last_addr = '0;
    while (!done && cyc < 30000) begin
      if (bus.RAM_WE) begin
        if (bus.RAM_ADDR != ADDR_W'(exp_a) || bus.RAM_WDATA != 4'h3) bad++;
        exp_a++;
        wr++;
      end
      if (!bus.CLR_BUSY) begin
        done = 1'b1;
        last_we = bus.RAM_WE;
        last_addr = bus.RAM_ADDR;
        bus.A_REQ = 1'b0;
      end else begin
        if (cyc % 4 == 0) begin
          va = va + 19'd1;
          bus.VGA_ADDR = va;
        end
        #1;
        if (bus.A_ACK) bad++;
        step();
        cyc++;
      end
    end
    bus.A_REQ = 1'b0;
    chk("clr_done", done, 1);
    chk("clr_writes", wr, FB_WORDS);
    chk("clr_bad", bad, 0);
    chk("clr_last_we", last_we, 1);
    chk("clr_last_addr", last_addr, FB_WORDS - 1);
    step();
    chk("clr_mem_first", mem[0], 3);
    chk("clr_mem_last", mem[FB_WORDS-1], 3);

    // Reset during a clear at counter 100
    bus.VGA_ADDR  = 19'd7;
    bus.CLR_START = 1'b1;
    bus.CLR_COLOR = 4'h5;
    step();
    bus.CLR_START = 1'b0;
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 300) begin
      if (bus.RAM_WE && bus.RAM_ADDR == 19'd99) found = 1'b1;
      else begin
        step();
        cyc++;
      end
    end
    chk("mid_found", found, 1);
    rst = 1'b1;
    step();
    chk("mid_busy", bus.CLR_BUSY, 0);
    chk("mid_we", bus.RAM_WE, 0);
    rst = 1'b0;
    step();
    chk("mid_rd_addr", bus.RAM_ADDR, 7);
    chk("mid_rd_we", bus.RAM_WE, 0);
    chk("mid_busy_low", bus.CLR_BUSY, 0);
    step();
    step();
    chk("mid_vga_data", bus.VGA_DATA, 5);
    chk("mid_mem99", mem[99], 5);
    chk("mid_mem100", mem[100], 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares one single-port 160x120x4 frame-buffer RAM between three users:
  - the VGA scan-out path, which gets the highest priority;
  - a built-in clear engine;
  - two write requesters, A (CPU) and B (draw engine), served round-robin.
- The block sits between the VGA timing generator and the frame-buffer RAM.
- It turns the generator's scaled pixel address into a registered pixel value.
- It slots writes into the cycles the scan-out path does not use.

Parameters:
- ADDR_W, 19: width of every address bus.
- DATA_W, 4: pixel width.
- FB_WORDS, 19200: number of frame-buffer words (160*120). Valid addresses are 0..FB_WORDS-1.

Ports:
- VGA_CLK  in  1  pixel clock; the single clock for the block.
- RESET  in  1  synchronous reset, active-high.
- VGA_ADDR  in  ADDR_W  scaled pixel address from the VGA timing generator.
- VGA_DATA  out  DATA_W  registered pixel value returned to the timing generator.
- A_REQ  in  1  writer A has a valid write.
- A_ADDR  in  ADDR_W  writer A address.
- A_DATA  in  DATA_W  writer A pixel.
- A_ACK  out  1  combinational; the write transfers on a rising edge where A_REQ and A_ACK are both high.
- B_REQ, B_ADDR, B_DATA, B_ACK: same as writer A, for writer B.
- CLR_START  in  1  start-clear pulse.
- CLR_COLOR  in  DATA_W  fill value, sampled on an accepted CLR_START.
- CLR_BUSY  out  1  high while a clear is running.
- RAM_ADDR  out  ADDR_W  registered RAM address.
- RAM_WDATA  out  DATA_W  registered RAM write data.
- RAM_WE  out  1  registered RAM write enable.
- RAM_RDATA  in  DATA_W  RAM read data, valid one cycle after the address is presented.

Behaviour:
- Reset (synchronous, RESET high at an edge):
  - VGA_DATA, RAM_ADDR, RAM_WDATA, RAM_WE, CLR_BUSY = 0.
  - Clear engine returns to IDLE and its counter goes to 0; any clear in progress is abandoned and the partial fill is left in RAM.
  - Round-robin pointer points to A, so B wins the first tie.
  - Previous-address register gets a flag forcing a read on the first cycle after reset.
- Read detection:
  - rd_req = (VGA_ADDR != prev_addr) or the force flag is set.
  - prev_addr is updated every cycle.
- Read issue: when rd_req is high and VGA_ADDR < FB_WORDS, the next edge loads RAM_ADDR = VGA_ADDR and RAM_WE = 0.
- Out-of-range read: when rd_req is high and VGA_ADDR >= FB_WORDS (blanking wrap), no RAM access is made. The cycle is not consumed and VGA_DATA is forced to 0 with the same latency as a real read.
- Read latency:
  - Address change in cycle t; RAM address registered at the end of t; RAM_RDATA valid in t+2; VGA_DATA updated at the end of t+2 and visible from t+3.
  - A 2-bit in-flight pipeline tracks this; VGA_DATA holds its value between reads.
- Priority per cycle: in-range read > clear > writers. Exactly one RAM access per cycle at most.
- Clear engine, two states:
  - IDLE -> CLEAR on CLR_START while IDLE. The counter is set to 0, CLR_COLOR is latched and CLR_BUSY = 1 from the next cycle.
  - In CLEAR, every cycle not taken by a read writes the latched colour to the counter address (RAM_WE = 1), then the counter increments.
  - CLEAR -> IDLE after the write to FB_WORDS-1 is issued; CLR_BUSY falls on that same edge.
  - CLR_START while in CLEAR is ignored.
  - A_ACK and B_ACK are 0 throughout CLEAR.
- Writers (only in IDLE, only when no in-range read is pending):
  - One requester high: it is acked.
  - Both high: the requester other than the round-robin pointer is acked, then the pointer moves to the winner.
  - An acked write registers RAM_ADDR, RAM_WDATA and RAM_WE = 1 on that edge.
  - An acked write with address >= FB_WORDS is consumed (ACK = 1) but RAM_WE = 0.
  - A requester holding REQ after an ack is presenting a new write.
- Idle cycles: RAM_WE = 0 and RAM_ADDR holds its value.
- Bandwidth: the timing generator changes address at most every 4 cycles, so writers and clear get at least 3 of every 4 cycles during active video.

Test Plan:
- Reset, then preload RAM[5] = 0xA and drive VGA_ADDR 4 -> 5 at cycle 10 -> RAM_ADDR = 5 and RAM_WE = 0 in cycle 11; VGA_DATA = 0xA from cycle 13.
- A_REQ and B_REQ held high with distinct addresses, VGA_ADDR static -> acks alternate B, A, B, A on consecutive cycles, each followed next cycle by RAM_WE = 1 at the matching address and data.
- A_REQ high and VGA_ADDR changes in the same cycle -> A_ACK = 0 that cycle, the read is issued, and A is acked the following cycle.
- CLR_START with CLR_COLOR = 0x3, VGA_ADDR changing every 4 cycles -> exactly 19200 writes of 0x3 covering addresses 0..19199. CLR_BUSY stays high and A_ACK stays 0 throughout; CLR_BUSY falls on the edge of the last write.
- VGA_ADDR = 0x7FFF0 (out of range) -> no RAM access is made and VGA_DATA = 0 three cycles later; A_ADDR = 19200 -> A_ACK = 1 with RAM_WE = 0.
- RESET asserted mid-clear at counter 100 -> next cycle CLR_BUSY = 0 and RAM_WE = 0, and the first post-reset cycle issues a read of the current VGA_ADDR.
